down_counter: RTL

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/down_counter_pkg.sv | 21 ++
 rtl/down_counter_sat_sub.sv | 26 ++
 rtl/down_counter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/down_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_pkg
// Description : Shared types and constants for the down_counter block:
//               FSM state encoding and the default counter resolution.
// Revision    : 1.0 - initial release
// ============================================================================
package down_counter_pkg;

  // Default width of the counter and step operands, in bits.
  localparam int unsigned DEFAULT_RESOLUTION = 64;

  // Counter control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : down_counter_pkg
`default_nettype wire

// File: rtl/down_counter_sat_sub.sv
`default_nettype none
// ============================================================================
// Module      : sat_sub
// Description : Unsigned subtractor a - b that clamps at zero, with a flag
//               reporting a <= b (the count would reach or cross zero).
// Revision    : 1.0 - initial release
// ============================================================================
module sat_sub
  import down_counter_pkg::*;
#(
  parameter int unsigned RESOLUTION = DEFAULT_RESOLUTION
) (
  input  logic [RESOLUTION-1:0] a,
  input  logic [RESOLUTION-1:0] b,
  output logic [RESOLUTION-1:0] diff,
  output logic                  a_le_b
);

  // Clamp the difference to zero whenever the subtrahend covers the minuend.
  always_comb begin
    a_le_b = (a <= b);
    diff   = a_le_b ? '0 : (a - b);
  end

endmodule : sat_sub
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
// Module      : down_counter
// Description : Loadable saturating down counter with IDLE/RUN/DONE control,
//               registered one-cycle underflow pulse and synchronous abort.
//               Optional periodic mode: define DOWN_COUNTER_AUTO_RELOAD_EN to
//               reload the last loaded value on underflow and stay in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter
  import down_counter_pkg::*;
#(
  parameter int unsigned RESOLUTION = DEFAULT_RESOLUTION
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RESOLUTION-1:0] load_value,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [RESOLUTION-1:0] decrement,
  input  logic                  enable,
  input  logic                  abort,
  output logic [RESOLUTION-1:0] counter_out,
  output logic                  underflow,
  output logic                  busy
);

  state_t                  state_q, state_d;
  logic [RESOLUTION-1:0]   count_q, count_d;
  logic                    underflow_q, underflow_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [RESOLUTION-1:0]   reload_q, reload_d;
`endif

  logic [RESOLUTION-1:0]   step_diff;
  logic                    step_hits_zero;

  sat_sub #(
    .RESOLUTION (RESOLUTION)
  ) u_sat_sub (
    .a      (count_q),
    .b      (decrement),
    .diff   (step_diff),
    .a_le_b (step_hits_zero)
  );

  // Next-state, next-count and underflow pulse; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    underflow_d = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d    = reload_q;
`endif
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load_valid) begin
            count_d = load_value;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_d = load_value;
`endif
            // A zero load finishes immediately so no zero-period loop can form.
            if (load_value == '0) begin
              state_d     = DONE;
              underflow_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (enable) begin
            if (step_hits_zero) begin
              underflow_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = DONE;
`endif
            end else begin
              count_d = step_diff;
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State, count and pulse registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      underflow_q <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q    <= reload_d;
`endif
    end
  end

  // Outputs derived directly from registered state.
  always_comb begin
    counter_out = count_q;
    underflow   = underflow_q;
    busy        = (state_q == RUN);
    load_ready  = (state_q != RUN);
  end

endmodule : down_counter
`default_nettype wire
